// File: rtl/spindle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spindle_pkg
// Brief    : Shared fiber encodings, FSM states and width helper.
// Revision : 1.0
// ============================================================================
package spindle_pkg;

    localparam int         FIBER_W     = 2;
    localparam logic [1:0] FIBER_BAG1  = 2'd0;
    localparam logic [1:0] FIBER_BAG2  = 2'd1;
    localparam logic [1:0] FIBER_CHAIN = 2'd2;

    localparam int         ST_W     = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spindle_wb_delay.sv
`default_nettype none
// ============================================================================
// Module   : spindle_wb_delay
// Brief    : Write-back tuple delay line; MSB of the tuple is the valid bit.
// Revision : 1.0
// ============================================================================
module spindle_wb_delay #(
    parameter int DEPTH = 3,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o
);

    if (DEPTH == 0) begin : g_wire
        assign dout_o  = din_i;
        assign empty_o = 1'b1;
    end else begin : g_shift
        logic [W-1:0] stage_q [DEPTH];
        logic         pending;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= din_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        // The last stage is being written back this cycle, so only earlier
        // stages count as still in flight.
        always_comb begin
            pending = 1'b0;
            for (int i = 0; i < DEPTH - 1; i++) pending = pending | stage_q[i][W-1];
        end

        assign dout_o  = stage_q[DEPTH-1];
        assign empty_o = ~pending;
    end

endmodule
`default_nettype wire

// File: rtl/spindle_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spindle_step_sequencer
// Brief    : Issues all (spindle, fiber) jobs of one step to the shared datapath.
// Revision : 1.0
// ============================================================================
module spindle_step_sequencer
    import spindle_pkg::*;
#(
    parameter  int NUM_SPINDLES = 4,
    parameter  int PIPE_LAT     = 3,
    localparam int IDX_W        = idx_w(NUM_SPINDLES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step,
    input  logic             enable,
    input  logic             overrun_clr,
    output logic             busy,
    output logic             issue,
    output logic [IDX_W-1:0] spindle_sel,
    output logic [1:0]       fiber_sel,
    output logic             wb_en,
    output logic [IDX_W-1:0] wb_spindle,
    output logic [1:0]       wb_fiber,
    output logic             mix_en,
    output logic             step_done,
    output logic             overrun,
    output logic [31:0]      step_count
);

    localparam int               WB_W       = 1 + IDX_W + FIBER_W;
    localparam logic [IDX_W-1:0] LAST_SPDL  = IDX_W'(NUM_SPINDLES - 1);

    logic [ST_W-1:0]  state_q, state_d;
    logic             issue_q, issue_d;
    logic [IDX_W-1:0] spindle_q, spindle_d;
    logic [1:0]       fiber_q, fiber_d;
    logic             busy_q, done_q, overrun_q;
    logic [31:0]      count_q;
    logic [WB_W-1:0]  wb_in, wb_out;
    logic             wb_empty;

    always_comb begin
        state_d   = state_q;
        issue_d   = issue_q;
        spindle_d = spindle_q;
        fiber_d   = fiber_q;
        case (state_q)
            ST_IDLE: begin
                if (step && enable) begin
                    state_d   = ST_ISSUE;
                    issue_d   = 1'b1;
                    spindle_d = '0;
                    fiber_d   = FIBER_BAG1;
                end
            end
            ST_ISSUE: begin
                // Selects keep the last job so the datapath operands stay stable.
                if (spindle_q == LAST_SPDL && fiber_q == FIBER_CHAIN) begin
                    issue_d = 1'b0;
                    state_d = (PIPE_LAT > 0) ? ST_DRAIN : ST_DONE;
                end else if (fiber_q == FIBER_CHAIN) begin
                    fiber_d   = FIBER_BAG1;
                    spindle_d = spindle_q + 1'b1;
                end else begin
                    fiber_d = fiber_q + 2'd1;
                end
            end
            ST_DRAIN: begin
                if (wb_empty) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            issue_q   <= 1'b0;
            spindle_q <= '0;
            fiber_q   <= FIBER_BAG1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            issue_q   <= issue_d;
            spindle_q <= spindle_d;
            fiber_q   <= fiber_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
            if (state_q == ST_DONE) count_q <= count_q + 32'd1;
            if (step && state_q != ST_IDLE) overrun_q <= 1'b1;
            else if (overrun_clr)           overrun_q <= 1'b0;
        end
    end

    // Invalid slots carry zeros so wb_spindle/wb_fiber read 0 when idle.
    assign wb_in = issue_q ? {1'b1, spindle_q, fiber_q} : '0;

    spindle_wb_delay #(
        .DEPTH (PIPE_LAT),
        .W     (WB_W)
    ) u_wb_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .din_i   (wb_in),
        .dout_o  (wb_out),
        .empty_o (wb_empty)
    );

    assign {wb_en, wb_spindle, wb_fiber} = wb_out;
    assign mix_en      = wb_en && (wb_fiber == FIBER_CHAIN);
    assign busy        = busy_q;
    assign issue       = issue_q;
    assign spindle_sel = spindle_q;
    assign fiber_sel   = fiber_q;
    assign step_done   = done_q;
    assign overrun     = overrun_q;
    assign step_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_spindle_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spindle_step_sequencer
// Brief    : Scoreboard bench for a 4-spindle/LAT3 and a 1-spindle/LAT0 instance.
// Revision : 1.0
// ============================================================================
module tb_spindle_step_sequencer;

    typedef struct {
        int cyc;
        int sp;
        int fb;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    logic        a_step = 0, a_en = 1, a_clr = 0;
    logic        a_busy, a_issue, a_wb_en, a_mix, a_done, a_ov;
    logic [1:0]  a_sp, a_fb, a_wbs, a_wbf;
    logic [31:0] a_cnt;

    logic        b_step = 0, b_en = 1, b_clr = 0;
    logic        b_busy, b_issue, b_wb_en, b_mix, b_done, b_ov;
    logic [0:0]  b_sp, b_wbs;
    logic [1:0]  b_fb, b_wbf;
    logic [31:0] b_cnt;

    ev_t issA[$], wbA[$], doneA[$], cntA[$];
    ev_t issB[$], wbB[$], doneB[$], cntB[$];
    int  free_at[2];
    int  cnt_exp[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spindle_step_sequencer #(.NUM_SPINDLES(4), .PIPE_LAT(3)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .step(a_step), .enable(a_en), .overrun_clr(a_clr),
        .busy(a_busy), .issue(a_issue), .spindle_sel(a_sp), .fiber_sel(a_fb),
        .wb_en(a_wb_en), .wb_spindle(a_wbs), .wb_fiber(a_wbf), .mix_en(a_mix),
        .step_done(a_done), .overrun(a_ov), .step_count(a_cnt)
    );

    spindle_step_sequencer #(.NUM_SPINDLES(1), .PIPE_LAT(0)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .step(b_step), .enable(b_en), .overrun_clr(b_clr),
        .busy(b_busy), .issue(b_issue), .spindle_sel(b_sp), .fiber_sel(b_fb),
        .wb_en(b_wb_en), .wb_spindle(b_wbs), .wb_fiber(b_wbf), .mix_en(b_mix),
        .step_done(b_done), .overrun(b_ov), .step_count(b_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Expected schedule of one accepted step at cycle c for instance d.
    task automatic accept(input int d, input int c);
        int  n = (d == 0) ? 4 : 1;
        int  l = (d == 0) ? 3 : 0;
        ev_t e;
        for (int j = 0; j < 3 * n; j++) begin
            e.cyc = c + 1 + j; e.sp = j / 3; e.fb = j % 3;
            if (d == 0) issA.push_back(e); else issB.push_back(e);
            e.cyc = c + 1 + j + l;
            if (d == 0) wbA.push_back(e); else wbB.push_back(e);
        end
        e.sp = 0; e.fb = 0;
        e.cyc = c + 3 * n + l + 1;
        if (d == 0) doneA.push_back(e); else doneB.push_back(e);
        cnt_exp[d]++;
        e.cyc = c + 3 * n + l + 2; e.sp = cnt_exp[d];
        if (d == 0) cntA.push_back(e); else cntB.push_back(e);
        free_at[d] = c + 3 * n + l + 2;
    endtask

    task automatic go(input int k);
        while (cyc < k) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int d, input logic clr);
        if (d == 0) begin a_step = 1; a_clr = clr; end else b_step = 1;
        if (cyc >= free_at[d] && ((d == 0) ? a_en : b_en)) accept(d, cyc);
        @(posedge clk); #1;
        a_step = 0; a_clr = 0; b_step = 0;
    endtask

    task automatic mon(input int d, input logic iss, input int sp, input int fb,
                       input logic wbe, input int wsp, input int wfb, input logic mix,
                       input logic done, input logic busy, input logic [31:0] cnt);
        ev_t e;
        string nm = (d == 0) ? "A" : "B";
        int    sz;
        if (iss) begin
            sz = (d == 0) ? issA.size() : issB.size();
            if (sz == 0) check({nm, " unexpected issue"}, 1, 0);
            else begin
                if (d == 0) e = issA.pop_front(); else e = issB.pop_front();
                check({nm, " issue cycle"}, 64'(cyc), 64'(e.cyc));
                check({nm, " issue sel"}, 64'(sp * 4 + fb), 64'(e.sp * 4 + e.fb));
            end
        end
        if (wbe) begin
            sz = (d == 0) ? wbA.size() : wbB.size();
            if (sz == 0) check({nm, " unexpected wb"}, 1, 0);
            else begin
                if (d == 0) e = wbA.pop_front(); else e = wbB.pop_front();
                check({nm, " wb cycle"}, 64'(cyc), 64'(e.cyc));
                check({nm, " wb tuple"}, 64'(wsp * 4 + wfb), 64'(e.sp * 4 + e.fb));
                check({nm, " mix_en"}, 64'(mix), 64'(e.fb == 2));
            end
        end else begin
            check({nm, " wb idle zero"}, 64'(wsp * 8 + wfb * 2 + int'(mix)), 0);
        end
        if (done) begin
            sz = (d == 0) ? doneA.size() : doneB.size();
            if (sz == 0) check({nm, " unexpected step_done"}, 1, 0);
            else begin
                if (d == 0) e = doneA.pop_front(); else e = doneB.pop_front();
                check({nm, " step_done cycle"}, 64'(cyc), 64'(e.cyc));
                check({nm, " busy at done"}, 64'(busy), 1);
            end
        end
        sz = (d == 0) ? cntA.size() : cntB.size();
        if (sz > 0) begin
            e = (d == 0) ? cntA[0] : cntB[0];
            if (e.cyc == cyc) begin
                if (d == 0) void'(cntA.pop_front()); else void'(cntB.pop_front());
                check({nm, " step_count"}, 64'(cnt), 64'(e.sp));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_issue, int'(a_sp), int'(a_fb), a_wb_en, int'(a_wbs), int'(a_wbf), a_mix, a_done, a_busy, a_cnt);
        mon(1, b_issue, int'(b_sp), int'(b_fb), b_wb_en, int'(b_wbs), int'(b_wbf), b_mix, b_done, b_busy, b_cnt);
    end

    task automatic check_zero_a(input string tag);
        check({tag, " busy"}, 64'(a_busy), 0);
        check({tag, " issue"}, 64'(a_issue), 0);
        check({tag, " sel"}, 64'({a_sp, a_fb}), 0);
        check({tag, " wb"}, 64'({a_wb_en, a_wbs, a_wbf, a_mix}), 0);
        check({tag, " step_done"}, 64'(a_done), 0);
        check({tag, " overrun"}, 64'(a_ov), 0);
        check({tag, " step_count"}, 64'(a_cnt), 0);
    endtask

    initial begin
        free_at[0] = 0; free_at[1] = 0;
        cnt_exp[0] = 0; cnt_exp[1] = 0;
        go(1);
        check_zero_a("reset A");
        check("reset B outputs", 64'({b_busy, b_issue, b_wb_en, b_done, b_ov, b_cnt}), 0);
        go(2); reset_n = 1;

        go(5);  pulse(1, 0);
        go(10); pulse(0, 0);
        go(15);
        check("overrun before busy step", 64'(a_ov), 0);
        pulse(0, 0);
        check("overrun after busy step", 64'(a_ov), 1);
        go(30); a_clr = 1; @(posedge clk); #1; a_clr = 0;
        check("overrun cleared", 64'(a_ov), 0);

        go(40); pulse(0, 0);
        go(57); pulse(0, 0);
        check("no overrun back-to-back", 64'(a_ov), 0);
        go(62); pulse(0, 1);
        check("set wins over clear", 64'(a_ov), 1);
        go(64); a_clr = 1; @(posedge clk); #1; a_clr = 0;
        check("overrun cleared again", 64'(a_ov), 0);
        go(73); pulse(0, 0);
        check("step in done cycle overruns", 64'(a_ov), 1);
        pulse(0, 0);
        a_clr = 1; @(posedge clk); #1; a_clr = 0;

        go(95); a_en = 0; pulse(0, 0);
        go(97); pulse(0, 0);
        check("disabled steps no overrun", 64'(a_ov), 0);
        check("disabled steps no busy", 64'(a_busy), 0);

        go(100); a_en = 1; pulse(0, 0);
        go(102); a_en = 0;
        go(120); a_en = 1;

        go(130); pulse(0, 0);
        go(138); #2;
        reset_n = 0;
        issA.delete(); wbA.delete(); doneA.delete(); cntA.delete();
        issB.delete(); wbB.delete(); doneB.delete(); cntB.delete();
        free_at[0] = 0; free_at[1] = 0; cnt_exp[0] = 0; cnt_exp[1] = 0;
        #1;
        check_zero_a("async reset A");
        go(141); reset_n = 1;
        go(145); pulse(0, 0);
        go(170);

        check("A issue left", 64'(issA.size()), 0);
        check("A wb left", 64'(wbA.size()), 0);
        check("A done left", 64'(doneA.size()), 0);
        check("A count left", 64'(cntA.size()), 0);
        check("B issue left", 64'(issB.size()), 0);
        check("B wb left", 64'(wbB.size()), 0);
        check("A final step_count", 64'(a_cnt), 1);
        check("A idle at end", 64'(a_busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
